log_stream_arbiter: RTL

Packet-level round-robin arbiter sharing the mitigation node's single DMA-bound AXI stream between several log packet sources (marker keep-alive stream, mitigation event logs, diagnostics). Sits between the per-source packet generators and the DMA engine in the `sysClk` domain. Never interleaves beats of different packets, tags each beat with its source index and, when compiled in, aborts packets whose source stalls mid-packet.

---
 rtl/log_stream_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/log_stream_arbiter.sv
// rtl/log_stream_arbiter.sv - packet-level round-robin arbiter merging log sources onto one DMA stream
// Optional stall abort, flush and abort counter: define LOG_ARB_STALL_ABORT_EN.
module log_stream_arbiter #(
    parameter int    AXI_WIDTH   = 32,
    parameter int    PORT_COUNT  = 4,
    parameter int    STALL_LIMIT = 1000,
    parameter string DEBUG       = "false"
) (
    input  logic                            sysClk,
    input  logic                            sysReset,
    input  logic                            sysLogEnable,
    input  logic [PORT_COUNT*AXI_WIDTH-1:0] sTDATA,
    input  logic [PORT_COUNT-1:0]           sTVALID,
    input  logic [PORT_COUNT-1:0]           sTLAST,
    output logic [PORT_COUNT-1:0]           sTREADY,
    output logic [AXI_WIDTH-1:0]            mTDATA,
    output logic                            mTVALID,
    output logic                            mTLAST,
    output logic [$clog2(PORT_COUNT)-1:0]   mTUSER,
    input  logic                            mTREADY,
    output logic                            sysBusy,
    output logic [15:0]                     sysAbortCount
);

    localparam int UW = $clog2(PORT_COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    (* mark_debug = DEBUG *) state_t          r_state;
    (* mark_debug = DEBUG *) logic [UW-1:0]   r_grant;
    logic [UW-1:0]         r_last_grant;
    state_t                w_next;
    logic [UW-1:0]         w_sel;
    logic                  w_found;
    logic                  w_xfer;
    logic [PORT_COUNT-1:0] w_flush;
    logic [PORT_COUNT-1:0] w_eligible;
    logic                  w_unused_cfg;

    // Configuration values that only matter in some builds or to debug tooling.
    assign w_unused_cfg = (STALL_LIMIT > 0) ^ (DEBUG == "true");

`ifdef LOG_ARB_STALL_ABORT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [PORT_COUNT-1:0] r_flush;
    logic [SW-1:0]         r_stall;
    logic [15:0]           r_abort_count;
    logic [PORT_COUNT-1:0] w_flush_set;
    logic [PORT_COUNT-1:0] w_flush_clr;

    assign w_flush       = r_flush;
    assign sysAbortCount = r_abort_count;
    // The aborted port keeps draining until its own TLAST beat, so the rest of that packet never reaches the DMA.
    assign w_flush_clr   = r_flush & sTVALID & sTLAST;
    assign w_flush_set   = (r_state == S_ABORT && mTREADY) ? (PORT_COUNT'(1) << r_grant) : '0;
`else
    assign w_flush       = '0;
    assign sysAbortCount = '0;
`endif

    assign w_eligible = sTVALID & ~w_flush;
    assign sysBusy    = (r_state != S_IDLE);

    // Round-robin pick: first eligible requester after the last granted port, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_grant;
        for (int k = 1; k <= PORT_COUNT; k++) begin
            if (!w_found && w_eligible[(int'(r_last_grant) + k) % PORT_COUNT]) begin
                w_found = 1'b1;
                w_sel   = UW'((int'(r_last_grant) + k) % PORT_COUNT);
            end
        end
    end

    // Next state and stream muxing; GRANT is a zero-latency passthrough of the granted port.
    always_comb begin
        w_next  = r_state;
        sTREADY = w_flush;
        mTVALID = 1'b0;
        mTLAST  = 1'b0;
        mTUSER  = '0;
        mTDATA  = '0;
        w_xfer  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sysLogEnable && w_found)
                    w_next = S_GRANT;
            end
            S_GRANT: begin
                mTDATA           = sTDATA[r_grant*AXI_WIDTH +: AXI_WIDTH];
                mTVALID          = sTVALID[r_grant];
                mTLAST           = sTLAST[r_grant];
                mTUSER           = r_grant;
                sTREADY[r_grant] = mTREADY;
                w_xfer           = sTVALID[r_grant] && mTREADY;
                if (w_xfer && sTLAST[r_grant])
                    w_next = S_IDLE;
`ifdef LOG_ARB_STALL_ABORT_EN
                // Abort on the edge where the idle count reaches the limit, so no late beat can slip through.
                else if (!sTVALID[r_grant] && r_stall == SW'(STALL_LIMIT - 1))
                    w_next = S_ABORT;
`endif
            end
            S_ABORT: begin
                mTDATA  = '1;
                mTLAST  = 1'b1;
                mTVALID = 1'b1;
                mTUSER  = r_grant;
                if (mTREADY)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= UW'(PORT_COUNT - 1);
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_GRANT) begin
                r_grant      <= w_sel;
                r_last_grant <= w_sel;
            end
        end
    end

`ifdef LOG_ARB_STALL_ABORT_EN
    // Stall counter, flush flags and saturating abort counter.
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            r_stall       <= '0;
            r_flush       <= '0;
            r_abort_count <= '0;
        end else begin
            if (r_state != S_GRANT || w_xfer)
                r_stall <= '0;
            else if (!sTVALID[r_grant])
                r_stall <= r_stall + 1'b1;
            r_flush <= (r_flush & ~w_flush_clr) | w_flush_set;
            if (r_state == S_ABORT && mTREADY && r_abort_count != 16'hFFFF)
                r_abort_count <= r_abort_count + 16'd1;
        end
    end
`endif

endmodule
